// File: rtl/multi_zone_light_ctrl.sv
// multi_zone_light_ctrl
// N-zone smart-lighting controller. Every zone has its own button debouncer,
// AUTO / MAN_ON / MAN_OFF mode machine, presence hold timer and a relay
// driver that enforces a minimum off time before the relay may close again.
// Optional feature macro: LIGHT_NEIGHBOR_EN. When defined, presence in an
// adjacent zone (no wrap-around) also keeps an AUTO zone lit for half the
// hold time.

module multi_zone_light_ctrl #(
   parameter int N_ZONES         = 4,
   parameter int HOLD_CYCLES     = 3000,
   parameter int DEBOUNCE_CYCLES = 100,
   parameter int MIN_OFF_CYCLES  = 50
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_ZONES-1:0]     push_button,
   input  logic [N_ZONES-1:0]     infravermelho,
   output logic [N_ZONES-1:0]     led,
   output logic [N_ZONES-1:0]     saida,
   output logic [2*N_ZONES-1:0]   mode
);

   localparam int TW = $clog2(HOLD_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int OW = $clog2(MIN_OFF_CYCLES + 1);

   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);
   localparam logic [TW-1:0] HALF_LOAD = TW'(HOLD_CYCLES / 2);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [OW-1:0] OFF_MAX   = OW'(MIN_OFF_CYCLES);

   typedef enum logic [1:0] {
      AUTO    = 2'b00,
      MAN_ON  = 2'b01,
      MAN_OFF = 2'b10,
      ILLEGAL = 2'b11
   } zone_mode_t;

   logic [N_ZONES-1:0] btn_meta;
   logic [N_ZONES-1:0] btn_sync;
   logic [N_ZONES-1:0] ir_meta;
   logic [N_ZONES-1:0] ir_sync;

   logic [DW-1:0]      db_cnt [N_ZONES];
   logic [N_ZONES-1:0] btn_stable;
   logic [N_ZONES-1:0] press;

   zone_mode_t         state_q [N_ZONES];
   zone_mode_t         state_d [N_ZONES];

   logic [TW-1:0]      timer_q   [N_ZONES];
   logic [TW-1:0]      timer_dec [N_ZONES];
   logic [N_ZONES-1:0] nbr_presence;

   logic [OW-1:0]      off_cnt [N_ZONES];
   logic [N_ZONES-1:0] saida_d;

   // Bring the raw pins into the clock domain through two flops each
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta <= '0;
         btn_sync <= '0;
         ir_meta  <= '0;
         ir_sync  <= '0;
      end else begin
         btn_meta <= push_button;
         btn_sync <= btn_meta;
         ir_meta  <= infravermelho;
         ir_sync  <= ir_meta;
      end
   end

   // Accept a button level only after it has differed from the stable level
   // for DEBOUNCE_CYCLES samples in a row; a rising acceptance is a press
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ZONES; i++) begin
            db_cnt[i] <= '0;
         end
         btn_stable <= '0;
         press      <= '0;
      end else begin
         for (int i = 0; i < N_ZONES; i++) begin
            press[i] <= 1'b0;
            if (btn_sync[i] == btn_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]     <= '0;
               btn_stable[i] <= btn_sync[i];
               press[i]      <= btn_sync[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Mode state register per zone
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ZONES; i++) begin
            state_q[i] <= AUTO;
         end
      end else begin
         for (int i = 0; i < N_ZONES; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   // Each press steps the zone AUTO -> MAN_ON -> MAN_OFF -> AUTO
   always_comb begin
      for (int i = 0; i < N_ZONES; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            AUTO:    if (press[i]) state_d[i] = MAN_ON;
            MAN_ON:  if (press[i]) state_d[i] = MAN_OFF;
            MAN_OFF: if (press[i]) state_d[i] = AUTO;
            default: state_d[i] = AUTO;
         endcase
      end
   end

   // Presence seen in the adjacent zones, used only when neighbour lighting is built in
`ifdef LIGHT_NEIGHBOR_EN
   assign nbr_presence = (ir_sync << 1) | (ir_sync >> 1);
`else
   assign nbr_presence = '0;
`endif

   // Saturating one-step countdown of each hold timer
   always_comb begin
      for (int i = 0; i < N_ZONES; i++) begin
         timer_dec[i] = (timer_q[i] == '0) ? '0 : timer_q[i] - TW'(1);
      end
   end

   // Hold timer: a press or any manual mode forces zero, own presence reloads
   // the full hold, a neighbour only raises the timer up to half the hold
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ZONES; i++) begin
            timer_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_ZONES; i++) begin
            if (press[i] || (state_q[i] != AUTO)) begin
               timer_q[i] <= '0;
            end else if (ir_sync[i]) begin
               timer_q[i] <= HOLD_LOAD;
            end else if (nbr_presence[i] && (timer_dec[i] < HALF_LOAD)) begin
               timer_q[i] <= HALF_LOAD;
            end else begin
               timer_q[i] <= timer_dec[i];
            end
         end
      end
   end

   // Lamp request and mode bits decoded purely from registered state
   always_comb begin
      led  = '0;
      mode = '0;
      for (int i = 0; i < N_ZONES; i++) begin
         mode[2*i +: 2] = state_q[i];
         led[i]         = (state_q[i] == MAN_ON) ||
                          ((state_q[i] == AUTO) && (timer_q[i] != '0));
      end
   end

   // Relay may close only when already closed or after a full off period
   always_comb begin
      for (int i = 0; i < N_ZONES; i++) begin
         saida_d[i] = led[i] & (saida[i] | (off_cnt[i] == OFF_MAX));
      end
   end

   // Relay register and its off-time counter, restarted when the relay opens
   always_ff @(posedge clk) begin
      if (rst) begin
         saida <= '0;
         for (int i = 0; i < N_ZONES; i++) begin
            off_cnt[i] <= OFF_MAX;
         end
      end else begin
         saida <= saida_d;
         for (int i = 0; i < N_ZONES; i++) begin
            if (saida[i] && !saida_d[i]) begin
               off_cnt[i] <= '0;
            end else if (!saida[i] && (off_cnt[i] != OFF_MAX)) begin
               off_cnt[i] <= off_cnt[i] + OW'(1);
            end
         end
      end
   end

endmodule
